// File: rtl/dmem_responder.sv
// Load/store data-memory responder: one word request per handshake, LATENCY wait states, then a held response.
// Optional byte-lane write strobes are enabled with `define DMEM_RESPONDER_WSTRB_EN (adds input req_be).
`timescale 1ns/1ps

module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_RESPONDER_WSTRB_EN
    input  logic [3:0]  req_be,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int AW       = $clog2(DEPTH);
    localparam bit ZERO_LAT = (LATENCY == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [3:0]      waitCount;
    logic            capWe;
    logic            capErr;
    logic [AW-1:0]   capIdx;
    logic [31:0]     capWdata;
    logic [3:0]      capBe;

    logic [3:0]      reqBeLanes;
    logic            reqErr;
    logic            accept;
    logic            commit;
    logic            memWrite;
    logic [31:0]     memRead;

    logic            cmdWe;
    logic            cmdErr;
    logic [AW-1:0]   cmdIdx;
    logic [31:0]     cmdWdata;
    logic [3:0]      cmdBe;

`ifdef DMEM_RESPONDER_WSTRB_EN
    assign reqBeLanes = req_be;
`else
    assign reqBeLanes = 4'hF;
`endif

    assign reqErr = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
    assign accept = (state == IDLE) && req_valid && req_ready;
    assign commit = (accept && ZERO_LAT) || ((state == WAIT) && (waitCount == 4'd1));

    // With zero latency the commit edge is also the accept edge, so the live request is used.
    always_comb begin
        cmdWe    = capWe;
        cmdErr   = capErr;
        cmdIdx   = capIdx;
        cmdWdata = capWdata;
        cmdBe    = capBe;
        if (state == IDLE) begin
            cmdWe    = req_we;
            cmdErr   = reqErr;
            cmdIdx   = req_addr[AW+1:2];
            cmdWdata = req_wdata;
            cmdBe    = reqBeLanes;
        end
    end

    // reset is sampled so an edge that lands during reset never writes the array
    assign memWrite = reset && commit && cmdWe && !cmdErr;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            logic [7:0] laneMem [DEPTH];

            always_ff @(posedge clk) begin
                if (memWrite && cmdBe[gi]) begin
                    laneMem[cmdIdx] <= cmdWdata[gi*8 +: 8];
                end
            end

            assign memRead[gi*8 +: 8] = laneMem[cmdIdx];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            waitCount  <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            capWe      <= 1'b0;
            capErr     <= 1'b0;
            capIdx     <= '0;
            capWdata   <= '0;
            capBe      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        capWe     <= req_we;
                        capErr    <= reqErr;
                        capIdx    <= req_addr[AW+1:2];
                        capWdata  <= req_wdata;
                        capBe     <= reqBeLanes;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        waitCount <= 4'(LATENCY);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    waitCount <= waitCount - 4'd1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Entering RESP overrides the IDLE/WAIT updates above.
            if (commit) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= cmdErr;
                resp_rdata <= (cmdWe || cmdErr) ? 32'd0 : memRead;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/latency corner sequences and a randomized run against a word-array model.
`timescale 1ns/1ps

module tb_dmem_responder;
    localparam int DEPTH  = 256;
    localparam int LAT    = 2;
    localparam int ZDEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        reqValid, reqReady, reqWe, respValid, respReady, respErr, busy;
    logic [31:0] reqAddr, reqWdata, respRdata;
    logic [3:0]  reqBe;

    logic        zReqValid, zReqReady, zReqWe, zRespValid, zRespReady, zRespErr, zBusy;
    logic [31:0] zReqAddr, zReqWdata, zRespRdata;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata),
`ifdef DMEM_RESPONDER_WSTRB_EN
        .req_be(reqBe),
`endif
        .resp_valid(respValid), .resp_ready(respReady),
        .resp_rdata(respRdata), .resp_err(respErr), .busy(busy)
    );

    dmem_responder #(.DEPTH(ZDEPTH), .LATENCY(0)) dutZero (
        .clk(clk), .reset(reset),
        .req_valid(zReqValid), .req_ready(zReqReady), .req_we(zReqWe),
        .req_addr(zReqAddr), .req_wdata(zReqWdata),
`ifdef DMEM_RESPONDER_WSTRB_EN
        .req_be(4'hF),
`endif
        .resp_valid(zRespValid), .resp_ready(zRespReady),
        .resp_rdata(zRespRdata), .resp_err(zRespErr), .busy(zBusy)
    );

    int checks = 0;
    int fails  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Reference model: a plain word array plus the address legality rule.
    logic [31:0] memModel [DEPTH];

    function automatic void modelTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [3:0] be, output logic expErr, output logic [31:0] expData);
        logic [3:0] lanes;
`ifdef DMEM_RESPONDER_WSTRB_EN
        lanes = be;
`else
        lanes = 4'hF;
`endif
        expErr  = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
        expData = 32'd0;
        if (!expErr) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (lanes[b]) memModel[addr / 4][b*8 +: 8] = wdata[b*8 +: 8];
            end else begin
                expData = memModel[addr / 4];
            end
        end
    endfunction

    task automatic doTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int stall, input logic expErr, input logic [31:0] expData);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (reqReady !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_accept", reqReady, 1'b1);
        reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata; reqBe = be;
        @(posedge clk);
        #1;
        reqValid = 1'b0; reqWe = ~we; reqAddr = $urandom; reqWdata = $urandom; reqBe = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (respValid !== 1'b1) begin
                check("busy_in_wait", busy, 1'b1);
                check("req_ready_in_wait", reqReady, 1'b0);
            end
        end while (respValid !== 1'b1 && lat < 40);
        check("resp_latency", 32'(lat), 32'(LAT + 1));
        check("resp_rdata", respRdata, expData);
        check("resp_err", respErr, expErr);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_resp_valid", respValid, 1'b1);
            check("stall_rdata", respRdata, expData);
            check("stall_busy", busy, 1'b1);
            check("stall_req_ready", reqReady, 1'b0);
        end
        respReady = 1'b1;
        @(posedge clk);
        #1;
        respReady = 1'b0;
        @(negedge clk);
        check("post_resp_valid", respValid, 1'b0);
        check("post_resp_err", respErr, 1'b0);
        check("post_busy", busy, 1'b0);
        check("post_req_ready", reqReady, 1'b1);
        check("post_rdata_hold", respRdata, expData);
        $display("txn we=%0b addr=0x%08h wdata=0x%08h be=%h stall=%0d -> rdata=0x%08h err=%0b lat=%0d",
                 we, addr, wdata, be, stall, expData, expErr, lat);
    endtask

    task automatic zTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] expData);
        @(negedge clk);
        check("z_req_ready_idle", zReqReady, 1'b1);
        zReqValid = 1'b1; zReqWe = we; zReqAddr = addr; zReqWdata = wdata; zRespReady = 1'b1;
        @(posedge clk);
        #1;
        zReqValid = 1'b0;
        @(negedge clk);
        check("z_resp_valid_1cyc", zRespValid, 1'b1);
        check("z_req_ready_resp", zReqReady, 1'b0);
        check("z_busy_resp", zBusy, 1'b1);
        check("z_rdata", zRespRdata, expData);
        check("z_err", zRespErr, 1'b0);
        $display("ztxn we=%0b addr=0x%08h wdata=0x%08h -> rdata=0x%08h", we, addr, wdata, expData);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic        expErr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] d;
        logic [31:0] a;
        logic        w;
        logic [3:0]  be;

        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         0, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h0000_0012, 32'h0,         0, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 0, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         0, 1'b0, 32'h0BAD_F00D};
        vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         5, 1'b0, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 32'h0000_03FC, 32'h7777_7777, 1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_03FC, 32'h0,         2, 1'b0, 32'h7777_7777};
        vecs[9]  = '{1'b0, 32'h0000_03FE, 32'h0,         0, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         0, 1'b1, 32'h0};

        reqValid = 0; reqWe = 0; reqAddr = 0; reqWdata = 0; reqBe = 4'hF; respReady = 0;
        zReqValid = 0; zReqWe = 0; zReqAddr = 0; zReqWdata = 0; zRespReady = 0;

        // Reset state, and req_ready rising only one cycle after release.
        @(negedge clk);
        check("rst_req_ready", reqReady, 1'b0);
        check("rst_resp_valid", respValid, 1'b0);
        check("rst_resp_rdata", respRdata, 32'h0);
        check("rst_resp_err", respErr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_z_req_ready", zReqReady, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_req_ready_low", reqReady, 1'b0);
        @(negedge clk);
        check("release_req_ready_high", reqReady, 1'b1);

        // Zero-latency instance: back-to-back accesses.
        zTxn(1'b1, 32'h0, 32'h1111_2222, 32'h0);
        zTxn(1'b1, 32'h4, 32'h3333_4444, 32'h0);
        zTxn(1'b0, 32'h0, 32'h0, 32'h1111_2222);
        zTxn(1'b0, 32'h4, 32'h0, 32'h3333_4444);
        @(negedge clk);
        zRespReady = 1'b0;
        check("z_idle_valid", zRespValid, 1'b0);
        check("z_idle_ready", zReqReady, 1'b1);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) begin
            modelTxn(1'b1, 32'(i * 4), $urandom, 4'hF, e, d);
            doTxn(1'b1, 32'(i * 4), memModel[i], 4'hF, 0, e, d);
        end

        for (int i = 0; i < 11; i++) begin
            modelTxn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 4'hF, e, d);
            doTxn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 4'hF, vecs[i].stall, vecs[i].expErr, vecs[i].expData);
        end

        // Reset one cycle after accepting a write: the write must not land.
        modelTxn(1'b1, 32'h20, 32'hA5A5_A5A5, 4'hF, e, d);
        doTxn(1'b1, 32'h20, 32'hA5A5_A5A5, 4'hF, 0, e, d);
        doTxn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        check("midrst_ready_before", reqReady, 1'b1);
        reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'h1234_5678; reqBe = 4'hF;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_resp_valid", respValid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_req_ready", reqReady, 1'b0);
        check("midrst_rdata", respRdata, 32'h0);
        check("midrst_err", respErr, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        doTxn(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, 32'hA5A5_A5A5);

        // Reset after the commit edge: the write persists, the response is dropped.
        @(negedge clk);
        reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h24; reqWdata = 32'h5A5A_0001; reqBe = 4'hF;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        repeat (3) @(negedge clk);
        check("commit_resp_valid", respValid, 1'b1);
        reset = 1'b0;
        #1;
        check("postcommit_rst_valid", respValid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        memModel[9] = 32'h5A5A_0001;
        doTxn(1'b0, 32'h24, 32'h0, 4'hF, 0, 1'b0, 32'h5A5A_0001);

`ifdef DMEM_RESPONDER_WSTRB_EN
        modelTxn(1'b1, 32'h30, 32'hFFFF_FFFF, 4'hF, e, d);
        doTxn(1'b1, 32'h30, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h0);
        modelTxn(1'b1, 32'h30, 32'h0000_0000, 4'b0101, e, d);
        doTxn(1'b1, 32'h30, 32'h0000_0000, 4'b0101, 0, 1'b0, 32'h0);
        modelTxn(1'b1, 32'h30, 32'h1234_5678, 4'b0000, e, d);
        doTxn(1'b1, 32'h30, 32'h1234_5678, 4'b0000, 0, 1'b0, 32'h0);
        modelTxn(1'b0, 32'h30, 32'h0, 4'hF, e, d);
        doTxn(1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b0, 32'hFF00_FF00);
`endif

        // Randomized mix of legal, misaligned and out-of-range accesses.
        for (int i = 0; i < 200; i++) begin
            int r;
            r  = $urandom_range(0, 9);
            w  = 1'($urandom_range(0, 1));
            be = 4'($urandom);
            if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else             a = ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            modelTxn(w, a, $urandom, be, e, d);
            doTxn(w, a, (w && !e) ? memModel[a / 4] : 32'($urandom), be, $urandom_range(0, 2), e, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
